// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_ctrl
// Description : Next-PC sequencer for the instruction-fetch stage. Drives the
//               PC register load enable and next value, stalls fetch on
//               icache misses, holds redirects that arrive during a miss and
//               forces recovery to the exception vector on a long miss.
// Ports       :
//   clk         in   1   clock, rising edge
//   rstn        in   1   asynchronous reset, active-high (1 = in reset)
//   pc_cur      in  32   current PC register value
//   hit         in   1   icache hit for pc_cur
//   stall       in   1   downstream hazard stall, hold PC
//   br_taken    in   1   branch resolved taken (pulse)
//   br_target   in  32   branch target
//   jmp         in   1   jump (pulse)
//   jmp_target  in  32   jump target
//   exc         in   1   exception request (pulse)
//   pc_next     out 32   value for PC register
//   pc_load     out  1   PC register write enable
//   fetch_valid out  1   instruction at pc_cur is valid this cycle
//   flush       out  1   squash younger in-flight instructions
//   timeout     out  1   miss-timeout pulse
//   miss_cnt    out 16   cycles spent in current miss
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter logic [31:0] EXC_VECTOR   = 32'h0000_0080,
    parameter int          MISS_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [31:0] pc_cur,
    input  logic        hit,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp,
    input  logic [31:0] jmp_target,
    input  logic        exc,
    output logic [31:0] pc_next,
    output logic        pc_load,
    output logic        fetch_valid,
    output logic        flush,
    output logic        timeout,
    output logic [15:0] miss_cnt
);

    localparam logic [1:0]  c_st_boot = 2'd0;
    localparam logic [1:0]  c_st_run  = 2'd1;
    localparam logic [1:0]  c_st_miss = 2'd2;
    localparam logic [15:0] c_cnt_max = 16'(MISS_TIMEOUT - 1);

    logic [1:0]  r_state,       w_state_nxt;
    logic        r_pend_valid,  w_pend_valid_nxt;
    logic        r_pend_exc,    w_pend_exc_nxt;
    logic [31:0] r_pend_target, w_pend_target_nxt;
    logic [15:0] r_miss_cnt,    w_miss_cnt_nxt;

    // Word-aligned versions of every target
    logic [31:0] w_reset_tgt;
    logic [31:0] w_exc_tgt;
    logic [31:0] w_br_tgt;
    logic [31:0] w_jmp_tgt;
    logic [31:0] w_seq_pc;
    logic        w_run_redir;
    logic [31:0] w_run_tgt;

    assign w_reset_tgt = {RESET_PC[31:2], 2'b00};
    assign w_exc_tgt   = {EXC_VECTOR[31:2], 2'b00};
    assign w_br_tgt    = {br_target[31:2], 2'b00};
    assign w_jmp_tgt   = {jmp_target[31:2], 2'b00};
    assign w_seq_pc    = pc_cur + 32'd4;

    // RUN redirect source: exception, then held redirect, then branch, then jump
    assign w_run_redir = exc | r_pend_valid | br_taken | jmp;
    assign w_run_tgt   = exc          ? w_exc_tgt     :
                         r_pend_valid ? r_pend_target :
                         br_taken     ? w_br_tgt      : w_jmp_tgt;

    assign miss_cnt = r_miss_cnt;

    always_comb begin
        pc_load           = 1'b0;
        pc_next           = w_seq_pc;
        fetch_valid       = 1'b0;
        flush             = 1'b0;
        timeout           = 1'b0;
        w_state_nxt       = r_state;
        w_pend_valid_nxt  = r_pend_valid;
        w_pend_exc_nxt    = r_pend_exc;
        w_pend_target_nxt = r_pend_target;
        w_miss_cnt_nxt    = r_miss_cnt;

        case (r_state)
            c_st_boot: begin
                pc_load     = 1'b1;
                pc_next     = w_reset_tgt;
                w_state_nxt = c_st_run;
            end

            c_st_run: begin
                if (w_run_redir) begin
                    // Redirect wins over both stall and a miss on the old path
                    pc_load          = 1'b1;
                    pc_next          = w_run_tgt;
                    flush            = 1'b1;
                    w_pend_valid_nxt = 1'b0;
                    w_pend_exc_nxt   = 1'b0;
                end else if (!hit) begin
                    w_state_nxt    = c_st_miss;
                    w_miss_cnt_nxt = 16'd0;
                end else if (stall) begin
                    fetch_valid = 1'b1;
                end else begin
                    pc_load     = 1'b1;
                    pc_next     = w_seq_pc;
                    fetch_valid = 1'b1;
                end
            end

            c_st_miss: begin
                if (!hit && (r_miss_cnt == c_cnt_max)) begin
                    // Forced recovery also absorbs any request arriving now
                    timeout          = 1'b1;
                    pc_load          = 1'b1;
                    pc_next          = w_exc_tgt;
                    flush            = 1'b1;
                    w_pend_valid_nxt = 1'b0;
                    w_pend_exc_nxt   = 1'b0;
                    w_miss_cnt_nxt   = 16'd0;
                    w_state_nxt      = c_st_run;
                end else begin
                    if (exc) begin
                        w_pend_valid_nxt  = 1'b1;
                        w_pend_exc_nxt    = 1'b1;
                        w_pend_target_nxt = w_exc_tgt;
                        flush             = 1'b1;
                    end else if ((br_taken || jmp) && !(r_pend_valid && r_pend_exc)) begin
                        // A held exception is never displaced by a branch or jump
                        w_pend_valid_nxt  = 1'b1;
                        w_pend_exc_nxt    = 1'b0;
                        w_pend_target_nxt = br_taken ? w_br_tgt : w_jmp_tgt;
                        flush             = 1'b1;
                    end
                    if (hit) begin
                        w_state_nxt    = c_st_run;
                        w_miss_cnt_nxt = 16'd0;
                    end else begin
                        w_miss_cnt_nxt = r_miss_cnt + 16'd1;
                    end
                end
            end

            default: begin
                w_state_nxt = c_st_boot;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rstn) begin
        if (rstn) begin
            r_state       <= c_st_boot;
            r_pend_valid  <= 1'b0;
            r_pend_exc    <= 1'b0;
            r_pend_target <= 32'd0;
            r_miss_cnt    <= 16'd0;
        end else begin
            r_state       <= w_state_nxt;
            r_pend_valid  <= w_pend_valid_nxt;
            r_pend_exc    <= w_pend_exc_nxt;
            r_pend_target <= w_pend_target_nxt;
            r_miss_cnt    <= w_miss_cnt_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_ctrl
// Description : Self-checking bench for fetch_ctrl: directed vector table,
//               hand-written reset-during-miss sequence, and randomized
//               traffic compared against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam int          TO      = 4;
    localparam logic [31:0] RST_PC  = 32'h0000_0000;
    localparam logic [31:0] EXC_PC  = 32'h0000_0080;
    localparam logic [31:0] ALIGN   = 32'hFFFF_FFFC;

    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] pc_cur;
    logic        hit, stall, br_taken, jmp, exc;
    logic [31:0] br_target, jmp_target;
    logic [31:0] pc_next;
    logic        pc_load, fetch_valid, flush, timeout;
    logic [15:0] miss_cnt;

    int checks   = 0;
    int failures = 0;

    fetch_ctrl #(
        .RESET_PC    (RST_PC),
        .EXC_VECTOR  (EXC_PC),
        .MISS_TIMEOUT(TO)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .pc_cur     (pc_cur),
        .hit        (hit),
        .stall      (stall),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp        (jmp),
        .jmp_target (jmp_target),
        .exc        (exc),
        .pc_next    (pc_next),
        .pc_load    (pc_load),
        .fetch_valid(fetch_valid),
        .flush      (flush),
        .timeout    (timeout),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] pc;
        bit          h, s, b;
        logic [31:0] bt;
        bit          j;
        logic [31:0] jt;
        bit          e;
        bit          el;
        logic [31:0] en;
        bit          efv, efl, eto;
        logic [15:0] ec;
    } vec_t;

    vec_t tbl[$];

    // Reference model: fetch is booting, running or waiting on a miss; at
    // most one redirect is held while waiting.
    typedef struct {
        logic [31:0] tgt;
        bit          is_exc;
    } pend_t;

    bit          m_boot;
    bit          m_miss;
    int          m_cnt;
    pend_t       m_pend[$];
    logic [31:0] m_pc;

    task automatic add_row(input logic [31:0] pc, input bit h, s, b, input logic [31:0] bt,
                           input bit j, input logic [31:0] jt, input bit e,
                           input bit el, input logic [31:0] en, input bit efv, efl, eto,
                           input logic [15:0] ec);
        vec_t v;
        v.pc = pc; v.h = h; v.s = s; v.b = b; v.bt = bt; v.j = j; v.jt = jt; v.e = e;
        v.el = el; v.en = en; v.efv = efv; v.efl = efl; v.eto = eto; v.ec = ec;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic [31:0] pc, input bit h, s, b, input logic [31:0] bt,
                         input bit j, input logic [31:0] jt, input bit e);
        pc_cur = pc; hit = h; stall = s; br_taken = b; br_target = bt;
        jmp = j; jmp_target = jt; exc = e;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input bit el, input logic [31:0] en,
                            input bit efv, efl, eto, input logic [15:0] ec);
        chk({tag, " pc_load"}, {31'd0, pc_load}, {31'd0, el});
        if (el) chk({tag, " pc_next"}, pc_next, en);
        chk({tag, " fetch_valid"}, {31'd0, fetch_valid}, {31'd0, efv});
        chk({tag, " flush"}, {31'd0, flush}, {31'd0, efl});
        chk({tag, " timeout"}, {31'd0, timeout}, {31'd0, eto});
        chk({tag, " miss_cnt"}, {16'd0, miss_cnt}, {16'd0, ec});
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_boot = 1'b1;
        m_miss = 1'b0;
        m_cnt  = 0;
        m_pend.delete();
        m_pc   = 32'd0;
    endtask

    task automatic model_cycle(input logic [31:0] pc, input bit h, s, b, input logic [31:0] bt,
                               input bit j, input logic [31:0] jt, input bit e,
                               output bit el, output logic [31:0] en,
                               output bit efv, efl, eto, output logic [15:0] ec);
        logic [31:0] tgt;
        bit          redir;
        pend_t       p;
        el = 0; en = pc + 32'd4; efv = 0; efl = 0; eto = 0; ec = 16'(m_cnt);
        tgt = 32'd0;
        if (m_boot) begin
            el = 1; en = RST_PC; m_boot = 0;
        end else if (!m_miss) begin
            redir = 1;
            if (e)                      tgt = EXC_PC;
            else if (m_pend.size() > 0) tgt = m_pend[0].tgt;
            else if (b)                 tgt = bt & ALIGN;
            else if (j)                 tgt = jt & ALIGN;
            else                        redir = 0;
            if (redir) begin
                el = 1; en = tgt; efl = 1; m_pend.delete();
            end else if (!h) begin
                m_miss = 1; m_cnt = 0;
            end else if (s) begin
                efv = 1;
            end else begin
                el = 1; en = pc + 32'd4; efv = 1;
            end
        end else begin
            if (!h && m_cnt == TO - 1) begin
                eto = 1; el = 1; en = EXC_PC; efl = 1;
                m_pend.delete(); m_cnt = 0; m_miss = 0;
            end else begin
                if (e) begin
                    p.tgt = EXC_PC; p.is_exc = 1;
                    m_pend.delete(); m_pend.push_back(p); efl = 1;
                end else if ((b || j) && !(m_pend.size() > 0 && m_pend[0].is_exc)) begin
                    p.tgt = b ? (bt & ALIGN) : (jt & ALIGN); p.is_exc = 0;
                    m_pend.delete(); m_pend.push_back(p); efl = 1;
                end
                if (h) begin
                    m_miss = 0; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end
        end
    endtask

    initial begin
        bit          el, efv, efl, eto;
        logic [31:0] en;
        logic [15:0] ec;

        //        pc            h s b bt        j jt        e | el en            fv fl to cnt
        add_row(32'h0,         1,0,0,32'h0,    0,32'h0,    0,  1,32'h0,        0,0,0,0); // boot
        add_row(32'h0,         1,0,0,32'h0,    0,32'h0,    0,  1,32'h4,        1,0,0,0);
        add_row(32'h4,         1,0,0,32'h0,    0,32'h0,    0,  1,32'h8,        1,0,0,0);
        add_row(32'h8,         1,0,0,32'h0,    0,32'h0,    0,  1,32'hC,        1,0,0,0);
        add_row(32'hFFFF_FFFC, 1,0,0,32'h0,    0,32'h0,    0,  1,32'h0,        1,0,0,0); // wrap
        add_row(32'h0,         1,1,1,32'h1003, 0,32'h0,    0,  1,32'h1000,     0,1,0,0); // br over stall
        add_row(32'h1000,      1,1,0,32'h0,    0,32'h0,    0,  0,32'h0,        1,0,0,0); // stall
        add_row(32'h1000,      0,0,0,32'h0,    0,32'h0,    0,  0,32'h0,        0,0,0,0); // enter miss
        add_row(32'h1000,      0,0,0,32'h0,    1,32'h200,  0,  0,32'h0,        0,1,0,0);
        add_row(32'h1000,      0,0,1,32'h300,  0,32'h0,    0,  0,32'h0,        0,1,0,1);
        add_row(32'h1000,      1,0,0,32'h0,    0,32'h0,    0,  0,32'h0,        0,0,0,2); // hit returns
        add_row(32'h1000,      1,0,0,32'h0,    0,32'h0,    0,  1,32'h300,      0,1,0,0); // pending applied
        add_row(32'h300,       0,0,0,32'h0,    0,32'h0,    0,  0,32'h0,        0,0,0,0);
        add_row(32'h300,       0,0,0,32'h0,    0,32'h0,    1,  0,32'h0,        0,1,0,0); // exc latched
        add_row(32'h300,       0,0,1,32'h400,  0,32'h0,    0,  0,32'h0,        0,0,0,1); // br ignored
        add_row(32'h300,       1,0,0,32'h0,    0,32'h0,    0,  0,32'h0,        0,0,0,2);
        add_row(32'h300,       1,0,0,32'h0,    0,32'h0,    0,  1,32'h80,       0,1,0,0);
        add_row(32'h80,        0,0,0,32'h0,    0,32'h0,    0,  0,32'h0,        0,0,0,0);
        add_row(32'h80,        0,0,0,32'h0,    0,32'h0,    0,  0,32'h0,        0,0,0,0);
        add_row(32'h80,        0,0,0,32'h0,    0,32'h0,    0,  0,32'h0,        0,0,0,1);
        add_row(32'h80,        0,0,0,32'h0,    0,32'h0,    0,  0,32'h0,        0,0,0,2);
        add_row(32'h80,        0,0,0,32'h0,    0,32'h0,    0,  1,32'h80,       0,1,1,3); // timeout
        add_row(32'h80,        1,0,0,32'h0,    0,32'h0,    0,  1,32'h84,       1,0,0,0);
        add_row(32'h84,        1,0,1,32'h500,  0,32'h0,    1,  1,32'h80,       0,1,0,0); // exc beats br
        add_row(32'h80,        0,0,0,32'h0,    0,32'h0,    0,  0,32'h0,        0,0,0,0);
        add_row(32'h80,        0,0,0,32'h0,    0,32'h0,    0,  0,32'h0,        0,0,0,0);
        add_row(32'h80,        0,0,0,32'h0,    0,32'h0,    0,  0,32'h0,        0,0,0,1);
        add_row(32'h80,        0,0,0,32'h0,    0,32'h0,    0,  0,32'h0,        0,0,0,2);
        add_row(32'h80,        0,0,0,32'h0,    0,32'h0,    1,  1,32'h80,       0,1,1,3); // timeout + exc
        add_row(32'h80,        1,0,0,32'h0,    0,32'h0,    0,  1,32'h84,       1,0,0,0); // nothing held
        add_row(32'h84,        1,0,0,32'h0,    1,32'h207,  0,  1,32'h204,      0,1,0,0); // jmp in RUN

        // Reset state
        rstn = 1'b1;
        drive(32'h0, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        next_cycle();
        next_cycle();
        chk_outs("reset", 1, RST_PC, 0, 0, 0, 16'd0);
        rstn = 1'b0;

        // Directed vector table
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].pc, tbl[i].h, tbl[i].s, tbl[i].b, tbl[i].bt, tbl[i].j, tbl[i].jt, tbl[i].e);
            #2;
            chk_outs($sformatf("row%0d", i), tbl[i].el, tbl[i].en, tbl[i].efv, tbl[i].efl,
                     tbl[i].eto, tbl[i].ec);
            next_cycle();
        end

        // Reset asserted in the second miss cycle with a jump held
        drive(32'h204, 0, 0, 0, 32'h0, 0, 32'h0, 0);
        #2 chk_outs("rm_enter", 0, 32'h0, 0, 0, 0, 16'd0);
        next_cycle();
        drive(32'h204, 0, 0, 0, 32'h0, 1, 32'h600, 0);
        #2 chk_outs("rm_miss1", 0, 32'h0, 0, 1, 0, 16'd0);
        next_cycle();
        drive(32'h204, 0, 0, 0, 32'h0, 0, 32'h0, 0);
        #1 chk_outs("rm_miss2", 0, 32'h0, 0, 0, 0, 16'd1);
        rstn = 1'b1;
        #1 chk_outs("rm_async", 1, RST_PC, 0, 0, 0, 16'd0);
        next_cycle();
        chk_outs("rm_held", 1, RST_PC, 0, 0, 0, 16'd0);
        rstn = 1'b0;
        drive(32'h204, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        #2 chk_outs("rm_boot", 1, RST_PC, 0, 0, 0, 16'd0);
        next_cycle();
        drive(RST_PC, 1, 0, 0, 32'h0, 0, 32'h0, 0);
        #2 chk_outs("rm_run", 1, 32'h4, 1, 0, 0, 16'd0);
        next_cycle();
        drive(32'h4, 0, 0, 0, 32'h0, 0, 32'h0, 0);
        #2 chk_outs("rm_miss_a", 0, 32'h0, 0, 0, 0, 16'd0);
        next_cycle();
        #2 chk_outs("rm_miss_b", 0, 32'h0, 0, 0, 0, 16'd0);
        next_cycle();
        #2 chk_outs("rm_miss_c", 0, 32'h0, 0, 0, 0, 16'd1);
        next_cycle();

        // Randomized traffic against the reference model
        rstn = 1'b1;
        model_reset();
        next_cycle();
        rstn = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            bit          rh, rs, rb, rj, re;
            logic [31:0] rbt, rjt;
            rh  = ($urandom_range(0, 99) < 65);
            rs  = ($urandom_range(0, 99) < 25);
            rb  = ($urandom_range(0, 99) < 8);
            rj  = ($urandom_range(0, 99) < 6);
            re  = ($urandom_range(0, 99) < 4);
            rbt = $urandom;
            rjt = $urandom;
            drive(m_pc, rh, rs, rb, rbt, rj, rjt, re);
            model_cycle(m_pc, rh, rs, rb, rbt, rj, rjt, re, el, en, efv, efl, eto, ec);
            #2 chk_outs($sformatf("rnd%0d", n), el, en, efv, efl, eto, ec);
            if (el) m_pc = en;
            next_cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Next-PC sequencer for the instruction-fetch stage. It drives the load enable and next value of the PC register, and stalls fetch on instruction-cache misses. It holds branch, jump and exception redirects that arrive during a miss, and forces a recovery to the exception vector when a miss lasts too long. It sits between the PC register, the instruction cache hit signal and the decode/execute redirect sources.

## Interface
- RESET_PC, 32'h0000_0000, fetch address loaded after reset
- EXC_VECTOR, 32'h0000_0080, exception / timeout target
- MISS_TIMEOUT, 64, consecutive miss cycles before forced recovery (2..65535)

Ports:
- clk  in  1  clock, rising edge
- rstn  in  1  asynchronous reset, active-high (asserted = 1)
- pc_cur  in  32  current PC register value
- hit  in  1  icache hit for pc_cur
- stall  in  1  downstream hazard stall, hold PC
- br_taken  in  1  branch resolved taken (1-cycle pulse)
- br_target  in  32  branch target
- jmp  in  1  jump (1-cycle pulse)
- jmp_target  in  32  jump target
- exc  in  1  exception request (1-cycle pulse)
- pc_next  out  32  value for PC register
- pc_load  out  1  PC register write enable
- fetch_valid  out  1  instruction at pc_cur is valid this cycle
- flush  out  1  squash younger in-flight instructions
- timeout  out  1  miss-timeout pulse
- miss_cnt  out  16  cycles spent in current miss

## Operation
- States: BOOT, RUN, MISS. Reset forces BOOT, clears the pending redirect and sets miss_cnt to 0.
- All targets are used with bits [1:0] forced to 0. Sequential increment is pc_cur+4, modulo 2^32 (0xFFFF_FFFC wraps to 0).
- BOOT:
  - pc_load=1, pc_next=RESET_PC, fetch_valid=0, flush=0.
  - Next state RUN.
- RUN: redirect priority is exc, then pending, then br_taken, then jmp.
  - On any redirect: pc_load=1, pc_next=target, flush=1, fetch_valid=0. Pending is cleared. Stay in RUN. The redirect overrides both stall and hit.
  - Else if hit=0: pc_load=0, fetch_valid=0, go to MISS.
  - Else if stall=1: pc_load=0, fetch_valid=1.
  - Else: pc_load=1, pc_next=pc_cur+4, fetch_valid=1.
- MISS:
  - Default outputs: pc_load=0, fetch_valid=0, flush=0.
  - Redirect requests are latched into pend_valid/pend_target using the same priority. A newer request overwrites an older one, except that a pending exception is never overwritten by a branch or jump. flush=1 in the cycle a request is latched.
  - hit=1: go to RUN. miss_cnt is cleared. The pending redirect is applied in the next RUN cycle.
  - hit=0 with miss_cnt < MISS_TIMEOUT-1: miss_cnt increments.
  - hit=0 with miss_cnt = MISS_TIMEOUT-1:
    - Outputs: timeout=1, pc_load=1, pc_next=EXC_VECTOR, flush=1.
    - Pending is cleared, miss_cnt is cleared, next state RUN.
- miss_cnt is 0 outside MISS and saturates at MISS_TIMEOUT-1.

## Timing
- All outputs are combinational from the state, pend_* and inputs. State, pend_* and miss_cnt are registered.
- Outputs while reset is asserted: pc_load=1, pc_next=RESET_PC, fetch_valid=0, flush=0, timeout=0, miss_cnt=0.
- After reset deasserts, the first edge loads RESET_PC, and RUN begins on the following cycle.
- Latency:
  - RUN redirect: 1 cycle (the target appears in the PC register on the next edge).
  - Redirect latched in MISS: the target is loaded on the edge after the first RUN cycle.
  - Miss exit: hit=1 in MISS causes fetch_valid=1 no earlier than the next cycle.
- Simultaneous events:
  - exc with br_taken: exc wins.
  - timeout with an exc request in the same cycle: EXC_VECTOR is loaded once and pending stays clear.
- Reset mid-miss aborts the pending redirect and the counter with no further pc_load to the old target.

## Test plan
- Reset then hit=1 continuously, no stall -> pc_next sequence 0x0, 0x4, 0x8, 0xC. fetch_valid=1 from the first RUN cycle.
- pc_cur=0xFFFF_FFFC, hit=1 -> pc_next=0x0000_0000.
- RUN with stall=1 and br_taken=1, br_target=0x1003 in the same cycle -> pc_load=1, pc_next=0x1000, flush=1.
- hit=0 for 3 cycles, with jmp (target 0x200) then br_taken (target 0x300) pulsed during the miss, then hit=1 -> miss_cnt counts 0,1,2. After the miss, the first RUN cycle loads 0x300 with flush=1.
- During a miss, exc pulses, then br_taken (0x400) pulses, then hit returns -> EXC_VECTOR 0x80 is loaded, not 0x400.
- MISS_TIMEOUT=4, hit held at 0 -> on the 4th miss cycle: timeout=1 for one cycle, pc_next=0x80, pc_load=1, miss_cnt returns to 0. Asserting reset in the 2nd miss cycle instead -> pc_next=RESET_PC with no timeout.
